// File: rtl/scan_chain_tester.sv
// rtl/scan_chain_tester.sv - scan-chain load/capture/unload initiator with response compare
//
// Purpose: drives a DUT's 3-wire scan port. On START it shifts PATTERN in (MSB first),
// holds SCAN_SE low for CAPTURE_CYCLES functional cycles, shifts the response out with
// zero fill, compares the response against EXPECT and pulses DONE.
//
// Ports:
//   CLK, RESET        clock (rising edge), synchronous active-high reset
//   START             single-cycle request, only honoured in IDLE
//   PATTERN, EXPECT   stimulus and expected response, latched when START is accepted
//   SCAN_SO           from DUT scan_out
//   SCAN_SI, SCAN_SE  to DUT scan_in / scan_enable
//   BUSY, DONE        activity flag and one-cycle completion pulse
//   PASS, RESPONSE    compare result and captured response, held until the next START
//
// Optional feature (macro SCAN_MASK_EN): adds input MASK (1 = don't-care bit) and
// output MISMATCH, the masked difference between RESPONSE and EXPECT.

module scan_chain_tester #(
    parameter int CHAIN_LEN      = 4,
    parameter int CAPTURE_CYCLES = 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic [CHAIN_LEN-1:0] PATTERN,
    input  logic [CHAIN_LEN-1:0] EXPECT,
`ifdef SCAN_MASK_EN
    input  logic [CHAIN_LEN-1:0] MASK,
    output logic [CHAIN_LEN-1:0] MISMATCH,
`endif
    input  logic                 SCAN_SO,
    output logic                 SCAN_SI,
    output logic                 SCAN_SE,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 PASS,
    output logic [CHAIN_LEN-1:0] RESPONSE
);

    // One counter serves both the shift phases and the capture phase.
    localparam int CNT_MAX = (CHAIN_LEN > CAPTURE_CYCLES) ? CHAIN_LEN : CAPTURE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] LAST_CAP = CW'(CAPTURE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CAPTURE,
        S_UNLOAD,
        S_COMPARE,
        S_FINISH
    } state_t;

    state_t               state_q, state_d;
    state_t               ostate_q, ostate_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] pattern_q, pattern_d;
    logic [CHAIN_LEN-1:0] expect_q, expect_d;
    logic [CHAIN_LEN-1:0] response_q, response_d;
    logic                 si_q, si_d;
    logic                 se_q, se_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [CHAIN_LEN-1:0] shift_next;
    logic [CHAIN_LEN-1:0] diff;
`ifdef SCAN_MASK_EN
    logic [CHAIN_LEN-1:0] mask_q, mask_d;
    logic [CHAIN_LEN-1:0] mismatch_q, mismatch_d;
`endif

    // Newest scan-out bit enters at the LSB, so the DUT's last flop lands in the MSB.
    generate
        if (CHAIN_LEN == 1) begin : g_shift_one
            assign shift_next = SCAN_SO;
        end else begin : g_shift_many
            assign shift_next = {response_q[CHAIN_LEN-2:0], SCAN_SO};
        end
    endgenerate

`ifdef SCAN_MASK_EN
    assign diff = (response_q ^ expect_q) & ~mask_q;
`else
    assign diff = response_q ^ expect_q;
`endif

    // The scan pins are registered decodes of the current state, so they show each
    // state one cycle after the FSM enters it. ostate_q is the state the pins are
    // showing; response sampling and the compare follow it so they line up with the
    // shifts the DUT actually performs.
    always_comb begin
        state_d    = state_q;
        ostate_d   = state_q;
        cnt_d      = cnt_q;
        pattern_d  = pattern_q;
        expect_d   = expect_q;
        response_d = response_q;
        pass_d     = pass_q;
        si_d       = 1'b0;
        se_d       = (state_q == S_LOAD) || (state_q == S_UNLOAD);
        busy_d     = (state_q != S_IDLE);
        done_d     = (state_q == S_FINISH);
`ifdef SCAN_MASK_EN
        mask_d     = mask_q;
        mismatch_d = mismatch_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    pattern_d  = PATTERN;
                    expect_d   = EXPECT;
                    response_d = '0;
                    pass_d     = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_LOAD;
`ifdef SCAN_MASK_EN
                    mask_d     = MASK;
                    mismatch_d = '0;
`endif
                end
            end
            S_LOAD: begin
                // Pattern shifts left so its MSB is always the next bit to send.
                si_d      = pattern_q[CHAIN_LEN-1];
                pattern_d = pattern_q << 1;
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CAPTURE: begin
                if (cnt_q == LAST_CAP) begin
                    cnt_d   = '0;
                    state_d = S_UNLOAD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_UNLOAD: begin
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = S_COMPARE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_COMPARE: state_d = S_FINISH;
            S_FINISH:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        if (ostate_q == S_UNLOAD) begin
            response_d = shift_next;
        end
        if (ostate_q == S_COMPARE) begin
            pass_d = (diff == '0);
`ifdef SCAN_MASK_EN
            mismatch_d = diff;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            ostate_q   <= S_IDLE;
            cnt_q      <= '0;
            pattern_q  <= '0;
            expect_q   <= '0;
            response_q <= '0;
            si_q       <= 1'b0;
            se_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
`ifdef SCAN_MASK_EN
            mask_q     <= '0;
            mismatch_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ostate_q   <= ostate_d;
            cnt_q      <= cnt_d;
            pattern_q  <= pattern_d;
            expect_q   <= expect_d;
            response_q <= response_d;
            si_q       <= si_d;
            se_q       <= se_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
`ifdef SCAN_MASK_EN
            mask_q     <= mask_d;
            mismatch_q <= mismatch_d;
`endif
        end
    end

    assign SCAN_SI  = si_q;
    assign SCAN_SE  = se_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign PASS     = pass_q;
    assign RESPONSE = response_q;
`ifdef SCAN_MASK_EN
    assign MISMATCH = mismatch_q;
`endif

endmodule

// File: tb/tb_scan_chain_tester.sv
// tb/tb_scan_chain_tester.sv - randomized self-checking bench for scan_chain_tester

module tb_scan_chain_tester;

    localparam int N    = 4;
    localparam int KMAX = 15;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             START;
    logic [N-1:0]     PATTERN;
    logic [N-1:0]     EXPECT;
`ifdef SCAN_MASK_EN
    logic [N-1:0]     MASK;
    logic [N-1:0]     mism_w [2];
`endif
    logic [1:0]       so_w, si_w, se_w, busy_w, done_w, pass_w;
    logic [N-1:0]     resp_w [2];
    logic [N-1:0]     chain [2] = '{4'h0, 4'h0};
    bit               inv_mode = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    // Instance 0: one capture cycle; instance 1: two capture cycles.
    scan_chain_tester #(.CHAIN_LEN(N), .CAPTURE_CYCLES(1)) u_dut_c1 (
        .CLK(CLK), .RESET(RESET), .START(START), .PATTERN(PATTERN), .EXPECT(EXPECT),
`ifdef SCAN_MASK_EN
        .MASK(MASK), .MISMATCH(mism_w[0]),
`endif
        .SCAN_SO(so_w[0]), .SCAN_SI(si_w[0]), .SCAN_SE(se_w[0]), .BUSY(busy_w[0]),
        .DONE(done_w[0]), .PASS(pass_w[0]), .RESPONSE(resp_w[0])
    );

    scan_chain_tester #(.CHAIN_LEN(N), .CAPTURE_CYCLES(2)) u_dut_c2 (
        .CLK(CLK), .RESET(RESET), .START(START), .PATTERN(PATTERN), .EXPECT(EXPECT),
`ifdef SCAN_MASK_EN
        .MASK(MASK), .MISMATCH(mism_w[1]),
`endif
        .SCAN_SO(so_w[1]), .SCAN_SI(si_w[1]), .SCAN_SE(se_w[1]), .BUSY(busy_w[1]),
        .DONE(done_w[1]), .PASS(pass_w[1]), .RESPONSE(resp_w[1])
    );

    // Scan-chain device under each tester: shifts when enabled, otherwise runs its
    // functional clock (hold, or invert every flop when inv_mode is set).
    assign so_w[0] = chain[0][N-1];
    assign so_w[1] = chain[1][N-1];

    always @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (se_w[i])       chain[i] <= {chain[i][N-2:0], si_w[i]};
            else if (inv_mode) chain[i] <= ~chain[i];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // After load the chain holds the pattern; each inverting capture cycle flips it;
    // unload returns the chain contents with the last flop in the MSB.
    function automatic logic [N-1:0] ref_resp(input logic [N-1:0] pat, input bit inv, input int c);
        return (inv && (c % 2 == 1)) ? ~pat : pat;
    endfunction

    task automatic run_test(input string name, input logic [N-1:0] pat, input logic [N-1:0] exv,
                            input logic [N-1:0] msk, input bit inv,
                            input int busy_at, input int reset_at);
        logic [31:0]  se_t [2];
        logic [31:0]  si_t [2];
        logic [31:0]  bz_t [2];
        logic [31:0]  dn_t [2];
        logic [31:0]  se_e, si_e, bz_e, dn_e;
        logic [N-1:0] m_eff, r_ref;
        logic         p_ref;
        int           c, d;
`ifdef SCAN_MASK_EN
        m_eff = msk;
`else
        m_eff = '0;
`endif
        for (int i = 0; i < 2; i++) begin
            se_t[i] = '0; si_t[i] = '0; bz_t[i] = '0; dn_t[i] = '0;
        end
        @(negedge CLK);
        PATTERN  = pat;
        EXPECT   = exv;
`ifdef SCAN_MASK_EN
        MASK     = msk;
`endif
        inv_mode = inv;
        START    = 1'b1;
        for (int k = 0; k <= KMAX; k++) begin
            @(negedge CLK);
            START   = 1'b0;
            RESET   = 1'b0;
            PATTERN = N'($urandom);
            EXPECT  = N'($urandom);
`ifdef SCAN_MASK_EN
            MASK    = N'($urandom);
`endif
            for (int i = 0; i < 2; i++) begin
                c = i + 1;
                d = 2 * N + c + 2;
                se_t[i][k] = se_w[i];
                si_t[i][k] = si_w[i];
                bz_t[i][k] = busy_w[i];
                dn_t[i][k] = done_w[i];
                if (k == 0 || (reset_at != 0 && k == reset_at)) begin
                    check_eq($sformatf("%s c%0d k%0d resp_clear", name, c, k), 32'(resp_w[i]), 32'h0);
                    check_eq($sformatf("%s c%0d k%0d pass_clear", name, c, k), 32'(pass_w[i]), 32'h0);
                end
                if (reset_at == 0 && (k == d || k == KMAX)) begin
                    r_ref = ref_resp(pat, inv, c);
                    p_ref = (((r_ref ^ exv) & ~m_eff) == '0);
                    check_eq($sformatf("%s c%0d k%0d response", name, c, k), 32'(resp_w[i]), 32'(r_ref));
                    check_eq($sformatf("%s c%0d k%0d pass", name, c, k), 32'(pass_w[i]), 32'(p_ref));
`ifdef SCAN_MASK_EN
                    check_eq($sformatf("%s c%0d k%0d mismatch", name, c, k), 32'(mism_w[i]),
                             32'((r_ref ^ exv) & ~m_eff));
`endif
                end
            end
            if (k + 1 == busy_at) begin
                START   = 1'b1;
                PATTERN = '1;
            end
            if (k + 1 == reset_at) RESET = 1'b1;
            // START sampled on the edge that ends the FINISH cycle of the 1-capture tester.
            if (reset_at == 0 && k + 1 == 2 * N + 3) START = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            c = i + 1;
            d = 2 * N + c + 2;
            se_e = '0; si_e = '0; bz_e = '0; dn_e = '0;
            for (int k = 0; k <= KMAX; k++) begin
                if (reset_at == 0 || k < reset_at) begin
                    se_e[k] = (k >= 1 && k <= N) || (k >= N + c + 1 && k <= 2 * N + c);
                    si_e[k] = (k >= 1 && k <= N) ? pat[N-k] : 1'b0;
                    bz_e[k] = (k >= 1 && k <= d);
                    dn_e[k] = (k == d);
                end
            end
            check_eq($sformatf("%s c%0d se_trace", name, c), se_t[i], se_e);
            check_eq($sformatf("%s c%0d si_trace", name, c), si_t[i], si_e);
            check_eq($sformatf("%s c%0d busy_trace", name, c), bz_t[i], bz_e);
            check_eq($sformatf("%s c%0d done_trace", name, c), dn_t[i], dn_e);
        end
    endtask

    initial begin
        logic [N-1:0] pat, exv, msk;
        bit           inv;
        int           rst, bsy;

        // Reset together with START: reset must win.
        RESET   = 1'b1;
        START   = 1'b1;
        PATTERN = '1;
        EXPECT  = '0;
`ifdef SCAN_MASK_EN
        MASK    = '0;
`endif
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        START = 1'b0;
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 2; i++) begin
                check_eq($sformatf("reset c%0d j%0d se", i + 1, j), 32'(se_w[i]), 32'h0);
                check_eq($sformatf("reset c%0d j%0d si", i + 1, j), 32'(si_w[i]), 32'h0);
                check_eq($sformatf("reset c%0d j%0d busy", i + 1, j), 32'(busy_w[i]), 32'h0);
                check_eq($sformatf("reset c%0d j%0d done", i + 1, j), 32'(done_w[i]), 32'h0);
                check_eq($sformatf("reset c%0d j%0d pass", i + 1, j), 32'(pass_w[i]), 32'h0);
                check_eq($sformatf("reset c%0d j%0d resp", i + 1, j), 32'(resp_w[i]), 32'h0);
            end
            @(negedge CLK);
        end

        run_test("loopback", 4'b1011, 4'b1011, 4'b0000, 1'b0, 0, 0);
        run_test("mismatch", 4'b1011, 4'b1010, 4'b0000, 1'b0, 0, 0);
        run_test("capture_inv", 4'b0011, 4'b1100, 4'b0000, 1'b1, 0, 0);
        run_test("busy_start", 4'b1011, 4'b1011, 4'b0000, 1'b0, 5, 0);
        run_test("reset_mid", 4'b1011, 4'b1011, 4'b0000, 1'b0, 0, 7);
        run_test("after_reset", 4'b1011, 4'b1011, 4'b0000, 1'b0, 0, 0);
        run_test("mask_dc", 4'b1011, 4'b1010, 4'b0001, 1'b0, 0, 0);
        run_test("mask_none", 4'b1011, 4'b1010, 4'b0000, 1'b0, 0, 0);

        for (int t = 0; t < 12; t++) begin
            pat = N'($urandom);
            inv = 1'($urandom_range(0, 1));
            msk = N'($urandom);
            exv = ($urandom_range(0, 1) == 1) ? ref_resp(pat, inv, 1) : N'($urandom);
            rst = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0;
            bsy = (rst == 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 10)) : 0;
            run_test($sformatf("rand%0d", t), pat, exv, msk, inv, bsy, rst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
